// File: rtl/cordic_phase_ctrl.sv
// NCO front end for the sine_cosine CORDIC: phase accumulator, angle issue,
// latency-matched valid tracking and result capture.
module cordic_phase_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 32,
    parameter int LATENCY     = 16,
    parameter int AMPLITUDE   = 19896
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [ANGLE_WIDTH-1:0]       cfg_fcw,
    input  logic [ANGLE_WIDTH-1:0]       cfg_phase,
    input  logic                         enable,
    output logic [ANGLE_WIDTH-1:0]       angle,
    output logic [DATA_WIDTH-1:0]        Xin,
    output logic [DATA_WIDTH-1:0]        Yin,
    input  logic signed [DATA_WIDTH:0]   cordic_cos,
    input  logic signed [DATA_WIDTH:0]   cordic_sin,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH:0]   out_cos,
    output logic signed [DATA_WIDTH:0]   out_sin,
    output logic                         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_load;
    logic   w_issue;
    logic   w_pend;

    logic [ANGLE_WIDTH-1:0] r_phase;
    logic [ANGLE_WIDTH-1:0] r_fcw;
    logic [ANGLE_WIDTH-1:0] r_angle;

    // r_issue_d marks the cycle the angle register holds a fresh angle;
    // the pipe behind it spans the CORDIC latency.
    logic                   r_issue_d;
    logic [LATENCY-1:0]     r_vpipe;
    logic [LATENCY-1:0]     w_vlow;

    logic                   r_out_valid;
    logic signed [DATA_WIDTH:0] r_out_cos;
    logic signed [DATA_WIDTH:0] r_out_sin;

    // Top pipe bit is excluded so IDLE coincides with the last out_valid.
    assign w_vlow = r_vpipe << 1;
    assign w_pend = r_issue_d | (|w_vlow);

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_issue = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    w_load = 1'b1;
                end else if (enable) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (enable) begin
                    w_issue = 1'b1;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (enable) begin
                    w_issue = 1'b1;
                    w_next  = S_RUN;
                end else if (!w_pend) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_fcw       <= '0;
            r_angle     <= '0;
            r_issue_d   <= 1'b0;
            r_vpipe     <= '0;
            r_out_valid <= 1'b0;
            r_out_cos   <= '0;
            r_out_sin   <= '0;
        end else begin
            r_state   <= w_next;
            r_issue_d <= w_issue;
            r_vpipe   <= (r_vpipe << 1) | LATENCY'(r_issue_d);
            if (w_load) begin
                r_fcw   <= cfg_fcw;
                r_phase <= cfg_phase;
            end
            if (w_issue) begin
                r_angle <= r_phase;
                r_phase <= r_phase + r_fcw;
            end
            r_out_valid <= r_vpipe[LATENCY-1];
            if (r_vpipe[LATENCY-1]) begin
                r_out_cos <= cordic_cos;
                r_out_sin <= cordic_sin;
            end
        end
    end

    assign cfg_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign angle     = r_angle;
    assign Xin       = DATA_WIDTH'(AMPLITUDE);
    assign Yin       = '0;
    assign out_valid = r_out_valid;
    assign out_cos   = r_out_cos;
    assign out_sin   = r_out_sin;

endmodule

// File: tb/tb_cordic_phase_ctrl.sv
// Bench for cordic_phase_ctrl: ideal CORDIC stand-in, transaction-level
// reference model with per-cycle compare, directed and random stimulus.
module tb_cordic_phase_ctrl;

    localparam int L = 16;

    logic               clock;
    logic               reset;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [31:0]        cfg_fcw;
    logic [31:0]        cfg_phase;
    logic               enable;
    logic [31:0]        angle;
    logic [15:0]        Xin;
    logic [15:0]        Yin;
    logic signed [16:0] cordic_cos;
    logic signed [16:0] cordic_sin;
    logic               out_valid;
    logic signed [16:0] out_cos;
    logic signed [16:0] out_sin;
    logic               busy;

    int total = 0;
    int bad   = 0;

    cordic_phase_ctrl #(
        .DATA_WIDTH(16),
        .ANGLE_WIDTH(32),
        .LATENCY(L),
        .AMPLITUDE(19896)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_fcw(cfg_fcw),
        .cfg_phase(cfg_phase),
        .enable(enable),
        .angle(angle),
        .Xin(Xin),
        .Yin(Yin),
        .cordic_cos(cordic_cos),
        .cordic_sin(cordic_sin),
        .out_valid(out_valid),
        .out_cos(out_cos),
        .out_sin(out_sin),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic signed [16:0] fc(input logic [31:0] a);
        real r;
        r = 32764.0 * $cos(6.283185307179586 * real'(longint'({32'h0, a})) / 4294967296.0);
        return 17'(int'(r));
    endfunction

    function automatic logic signed [16:0] fs(input logic [31:0] a);
        real r;
        r = 32764.0 * $sin(6.283185307179586 * real'(longint'({32'h0, a})) / 4294967296.0);
        return 17'(int'(r));
    endfunction

    // Ideal CORDIC: angle seen in cycle n appears on the outputs in cycle n+L.
    logic signed [16:0] dc [L];
    logic signed [16:0] ds [L];
    initial begin
        for (int i = 0; i < L; i++) begin
            dc[i] = '0;
            ds[i] = '0;
        end
    end
    always @(posedge clock) begin
        dc[0] <= fc(angle);
        ds[0] <= fs(angle);
        for (int i = 1; i < L; i++) begin
            dc[i] <= dc[i-1];
            ds[i] <= ds[i-1];
        end
    end
    assign cordic_cos = dc[L-1];
    assign cordic_sin = ds[L-1];

    // Reference model: mode 0 idle, 1 run, 2 drain; issued angles wait in a
    // queue tagged with the cycle their result must be reported.
    int                 mc = 0;
    bit                 m_on = 0;
    int                 m_mode;
    logic [31:0]        m_phase, m_fcw, m_angle, m_tmp;
    bit                 m_ov, m_iss;
    logic signed [16:0] m_cos, m_sin;
    int                 dq[$];
    logic [31:0]        aq[$];

    always @(posedge clock) begin
        if (reset) begin
            m_mode  = 0;
            m_phase = '0;
            m_fcw   = '0;
            m_angle = '0;
            m_ov    = 0;
            m_cos   = '0;
            m_sin   = '0;
            dq.delete();
            aq.delete();
            m_on    = 1;
        end else begin
            m_ov = 0;
            if (dq.size() > 0 && dq[0] == mc + 1) begin
                m_ov  = 1;
                m_tmp = aq.pop_front();
                void'(dq.pop_front());
                m_cos = fc(m_tmp);
                m_sin = fs(m_tmp);
            end
            m_iss = 0;
            case (m_mode)
                0: begin
                    if (cfg_valid) begin
                        m_fcw   = cfg_fcw;
                        m_phase = cfg_phase;
                    end else if (enable) begin
                        m_mode = 1;
                    end
                end
                1: begin
                    if (enable) m_iss = 1;
                    else m_mode = 2;
                end
                default: begin
                    if (enable) begin
                        m_iss  = 1;
                        m_mode = 1;
                    end else if (dq.size() == 0) begin
                        m_mode = 0;
                    end
                end
            endcase
            if (m_iss) begin
                m_angle = m_phase;
                m_phase = m_phase + m_fcw;
                dq.push_back(mc + L + 2);
                aq.push_back(m_angle);
            end
        end
        mc++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkr(input string nm, input int act, input int exp, input int tol);
        total++;
        if (act < exp - tol || act > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d+-%0d at %0t", nm, act, exp, tol, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_on) begin
            chk("angle", 64'(angle), 64'(m_angle));
            chk("busy", 64'(busy), 64'(m_mode != 0));
            chk("cfg_ready", 64'(cfg_ready), 64'(m_mode == 0));
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("out_cos", 64'(out_cos), 64'(m_cos));
            chk("out_sin", 64'(out_sin), 64'(m_sin));
            chk("Xin", 64'(Xin), 64'(16'd19896));
            chk("Yin", 64'(Yin), 64'(16'd0));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(output int p);
        bit done;
        p    = 0;
        done = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (out_valid) p++;
            if (!busy) begin
                done = 1;
                break;
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout: busy still high after 80 cycles");
        end
    endtask

    logic [31:0] qa [4];
    int          qc [4];
    int          qs [4];
    int          lat;
    int          p;
    logic [31:0] a_last;

    initial begin
        qa = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        qc = '{32764, 0, -32764, 0};
        qs = '{0, 32764, 0, -32764};
        reset     = 1;
        cfg_valid = 0;
        cfg_fcw   = '0;
        cfg_phase = '0;
        enable    = 0;
        repeat (3) tick();
        reset = 0;
        tick();
        chk("rst_angle", 64'(angle), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ready", 64'(cfg_ready), 64'h1);
        chk("rst_ovalid", 64'(out_valid), 64'h0);
        chk("rst_cos", 64'(out_cos), 64'h0);

        // quarter-turn step: angle pattern, latency, quadrant values
        cfg_valid = 1;
        cfg_fcw   = 32'h4000_0000;
        cfg_phase = 32'h0;
        tick();
        cfg_valid = 0;
        enable    = 1;
        tick();
        tick();
        chk("q_first_angle", 64'(angle), 64'h0);
        chk("q_busy", 64'(busy), 64'h1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i <= 4) chk("q_angle", 64'(angle), 64'(qa[i % 4]));
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk("q_latency", 64'(lat), 64'(17));
        for (int k = 0; k < 4; k++) begin
            chkr("q_cos", int'(out_cos), qc[k], 8);
            chkr("q_sin", int'(out_sin), qs[k], 8);
            tick();
        end
        enable = 0;
        drain(p);

        // wrap, simultaneous cfg+enable, 5-sample burst
        cfg_valid = 1;
        enable    = 1;
        cfg_fcw   = 32'h1000_0000;
        cfg_phase = 32'hF000_0000;
        tick();
        chk("sim_busy", 64'(busy), 64'h0);
        cfg_valid = 0;
        tick();
        tick();
        chk("w_angle0", 64'(angle), 64'hF000_0000);
        tick();
        chk("w_angle1", 64'(angle), 64'h0);
        tick();
        chk("w_angle2", 64'(angle), 64'h1000_0000);
        tick();
        tick();
        enable = 0;
        drain(p);
        repeat (2) begin
            tick();
            if (out_valid) p++;
        end
        chk("burst_pulses", 64'(p), 64'(5));

        // config offered during RUN waits for IDLE
        enable = 1;
        tick();
        tick();
        tick();
        cfg_valid = 1;
        cfg_fcw   = 32'h2000_0000;
        cfg_phase = 32'h1234_5678;
        tick();
        chk("cfg_run_ready", 64'(cfg_ready), 64'h0);
        tick();
        enable = 0;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (cfg_ready) begin
                lat = i;
                break;
            end
        end
        chk("cfg_wait_found", 64'(lat >= 0), 64'h1);
        chk("cfg_idle_busy", 64'(busy), 64'h0);
        tick();
        cfg_valid = 0;
        enable    = 1;
        tick();
        tick();
        chk("cfg_new_a0", 64'(angle), 64'h1234_5678);
        tick();
        chk("cfg_new_a1", 64'(angle), 64'h3234_5678);

        // reset mid-run with the CORDIC still busy
        repeat (20) tick();
        reset  = 1;
        enable = 0;
        tick();
        reset = 0;
        chk("mrst_angle", 64'(angle), 64'h0);
        chk("mrst_busy", 64'(busy), 64'h0);
        chk("mrst_ovalid", 64'(out_valid), 64'h0);
        enable = 1;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk("mrst_quiet", 64'(out_valid), 64'h0);
        end
        enable = 0;
        drain(p);

        // two-cycle enable gap inside a run
        cfg_valid = 1;
        cfg_fcw   = 32'h0100_0000;
        cfg_phase = 32'h0000_0100;
        tick();
        cfg_valid = 0;
        enable    = 1;
        repeat (5) tick();
        a_last = angle;
        enable = 0;
        tick();
        tick();
        chk("gap_hold", 64'(angle), 64'(a_last));
        enable = 1;
        tick();
        chk("gap_resume0", 64'(angle), 64'(a_last + 32'h0100_0000));
        tick();
        chk("gap_resume1", 64'(angle), 64'(a_last + 32'h0200_0000));
        repeat (20) tick();
        enable = 0;
        drain(p);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            enable    = ($urandom_range(0, 3) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_fcw   = $urandom;
            cfg_phase = $urandom;
            tick();
        end
        reset     = 0;
        enable    = 0;
        cfg_valid = 0;
        drain(p);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_phase_ctrl.md
# cordic_phase_ctrl

Phase-accumulator front end and result-capture stage for the `sine_cosine` CORDIC pipeline. It generates a stream of rotation angles from a programmable frequency control word and drives the CORDIC `angle`, `Xin` and `Yin` inputs. It tracks the CORDIC pipeline latency with a valid shift register, then registers the returned cosine/sine pair with a qualifying `out_valid`. Together the two blocks form a numerically controlled oscillator.

## Interface
- `DATA_WIDTH`, 16: CORDIC data width; results are `DATA_WIDTH+1` bits.
- `ANGLE_WIDTH`, 32: phase/angle width; full scale 2^ANGLE_WIDTH = 360°.
- `LATENCY`, 16: cycles from `angle` driven to result valid on `cordic_cos`/`cordic_sin`; equals CORDIC `ITER`.
- `AMPLITUDE`, 19896: constant driven on `Xin`; ≈ 32767/1.6468, so the CORDIC output peaks near full scale.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `cfg_valid`, in, 1: configuration offer.
- `cfg_ready`, out, 1: configuration accepted when `cfg_valid & cfg_ready`.
- `cfg_fcw`, in, ANGLE_WIDTH: frequency control word (phase increment per sample).
- `cfg_phase`, in, ANGLE_WIDTH: initial phase loaded into the accumulator.
- `enable`, in, 1: run request.
- `angle`, out, ANGLE_WIDTH: registered angle to the CORDIC.
- `Xin`, out, DATA_WIDTH: constant `AMPLITUDE`.
- `Yin`, out, DATA_WIDTH: constant 0.
- `cordic_cos`, in, DATA_WIDTH+1: CORDIC `Xout`.
- `cordic_sin`, in, DATA_WIDTH+1: CORDIC `Yout`.
- `out_valid`, out, 1: result qualifier.
- `out_cos`, out, DATA_WIDTH+1: registered cosine.
- `out_sin`, out, DATA_WIDTH+1: registered sine.
- `busy`, out, 1: high in RUN or DRAIN.

## Operation
- States:
  - IDLE: `cfg_ready`=1. Handshake loads `fcw`←`cfg_fcw`, `phase`←`cfg_phase`. If `enable`=1 and no handshake occurs this cycle → RUN.
  - RUN: each cycle `angle`←`phase`, `phase`←`phase+fcw` (mod 2^ANGLE_WIDTH, natural wrap), a 1 enters the valid pipe. If `enable`=0 → DRAIN (no issue this cycle; a 0 enters the pipe).
  - DRAIN: 0s enter the pipe, `angle` holds. `enable`=1 → RUN, phase continues without reload. Pipe empty → IDLE.
- Config during RUN/DRAIN is not accepted (`cfg_ready`=0); `cfg_valid` held by the source until IDLE.
- Simultaneous handshake and `enable` in IDLE: config is loaded and the FSM stays IDLE; RUN starts the next cycle using the new values.
- Valid pipe is LATENCY bits deep. Its output registers `out_valid`; when that output is 1, `out_cos`/`out_sin` capture `cordic_cos`/`cordic_sin`; otherwise they hold.
- First angle issued after a config load equals `cfg_phase` exactly.
- No arithmetic on results; pass-through width is DATA_WIDTH+1, signed.

## Timing
- Reset values:
  - state IDLE; `cfg_ready`=1 from the first cycle after reset.
  - `phase`, `fcw`, `angle` = 0.
  - valid pipe all 0; `out_valid`=0; `out_cos`=`out_sin`=0; `busy`=0.
  - `Xin`/`Yin` are constants independent of reset.
- `angle` updates on the edge that samples RUN, one angle per cycle, no bubbles while `enable`=1.
- An angle driven in cycle n yields `out_valid`=1 in cycle n+LATENCY+1, with matching `out_cos`/`out_sin`.
- `busy` goes low in the same cycle the FSM enters IDLE; the last `out_valid` occurs at or before that cycle.
- Reset mid-RUN clears the valid pipe. In-flight CORDIC results are never reported, and `out_valid` stays 0 for the LATENCY+1 cycles after reset regardless of `cordic_*` activity.
- `enable` toggling 1→0→1 within DRAIN produces a gap-free phase sequence: the increment is skipped only for cycles without issue.

## Test plan
- Reset, load `fcw`=0x40000000 and `phase`=0, hold `enable`:
  - angles are 0, 0x40000000, 0x80000000, 0xC0000000, then repeat.
  - First `out_valid` arrives 17 cycles after the first angle.
  - cos/sin ≈ (32764, 0), (0, 32764), (-32764, 0), (0, -32764), each ±8.
- Load `fcw`=0x10000000, `phase`=0xF0000000: first angle 0xF0000000, second 0x00000000 (wrap), third 0x10000000.
- RUN 5 cycles, drop `enable`:
  - exactly 5 `out_valid` pulses; `busy` falls after the drain.
  - `cfg_ready`=0 until IDLE, then 1.
- `cfg_valid` asserted in RUN with `fcw`=0x20000000: no acceptance until IDLE; accepted the first IDLE cycle; the following run uses the new step.
- Assert `reset` for 1 cycle mid-RUN with the CORDIC still outputting: `out_valid`=0 for the next 17 cycles; `angle`=0, `busy`=0.
- `enable` pulsed low for 2 cycles in RUN: angle sequence continues from the last issued phase+fcw, and the `out_valid` stream shows a 2-cycle gap.
